// File: rtl/pll_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pll_seq_pkg: state encoding and helpers for the PLL reset sequencer   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package pll_seq_pkg;

  localparam logic [1:0] C_ST_RESET_PLL = 2'd0;
  localparam logic [1:0] C_ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] C_ST_STABILIZE = 2'd2;
  localparam logic [1:0] C_ST_RUN       = 2'd3;

  typedef enum logic [1:0] {
    ST_RESET_PLL = C_ST_RESET_PLL,
    ST_WAIT_LOCK = C_ST_WAIT_LOCK,
    ST_STABILIZE = C_ST_STABILIZE,
    ST_RUN       = C_ST_RUN
  } pll_state_t;

  // Holds at max_value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_lock_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pll_lock_sync: multi-flop synchronizer for the raw PLL locked signal  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module pll_lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pll_reset_sequencer: PLL reset, lock debounce/timeout and system      |
// | reset generation on the reference clock.                              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 1000000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pll_locked_async,
  input  logic             sw_rst_req,
  input  logic             clr_lock_lost,
  output logic             pll_rst,
  output logic             sys_reset_n,
  output logic [1:0]       state_o,
  output logic             lock_lost,
  output logic [CNT_W-1:0] relock_count,
  output logic [CNT_W-1:0] timeout_count
);

  localparam int C_MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int C_MAX_CYC = (C_MAX_A > STABLE_CYCLES) ? C_MAX_A : STABLE_CYCLES;
  localparam int C_CW      = (C_MAX_CYC > 1) ? $clog2(C_MAX_CYC) : 1;

  localparam logic [C_CW-1:0] C_RST_LAST     = C_CW'(PLL_RST_CYCLES - 1);
  localparam logic [C_CW-1:0] C_TIMEOUT_LAST = C_CW'(LOCK_TIMEOUT - 1);
  localparam logic [C_CW-1:0] C_STABLE_LAST  = C_CW'(STABLE_CYCLES - 1);
  localparam logic [31:0]     C_SAT_MAX      = 32'((64'd1 << CNT_W) - 64'd1);

  pll_state_t       r_state;
  pll_state_t       w_next;
  logic [C_CW-1:0]  r_cnt;
  logic             w_lk;
  logic             w_cnt_clr;
  logic             w_timeout;
  logic             w_loss;
  logic             w_pll_rst_d;
  logic             w_sys_reset_n_d;
  logic             r_pll_rst;
  logic             r_sys_reset_n;
  logic             r_lock_lost;
  logic [CNT_W-1:0] r_relock_count;
  logic [CNT_W-1:0] r_timeout_count;

  pll_lock_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (pll_locked_async),
    .q      (w_lk)
  );

  // State register; the cycle counter stops in RUN where no window applies.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_RESET_PLL;
      r_cnt         <= '0;
      r_pll_rst     <= 1'b1;
      r_sys_reset_n <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_pll_rst     <= w_pll_rst_d;
      r_sys_reset_n <= w_sys_reset_n_d;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (r_state != ST_RUN) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    if (sw_rst_req) begin
      w_next = ST_RESET_PLL;
    end else begin
      case (r_state)
        ST_RESET_PLL: if (r_cnt == C_RST_LAST) w_next = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (w_lk)                          w_next = ST_STABILIZE;
          else if (r_cnt == C_TIMEOUT_LAST)  w_next = ST_RESET_PLL;
        end
        ST_STABILIZE: begin
          if (!w_lk)                         w_next = ST_WAIT_LOCK;
          else if (r_cnt == C_STABLE_LAST)   w_next = ST_RUN;
        end
        ST_RUN:       if (!w_lk) w_next = ST_RESET_PLL;
        default:      w_next = ST_RESET_PLL;
      endcase
    end
  end

  always_comb begin
    w_pll_rst_d     = (w_next == ST_RESET_PLL);
    w_sys_reset_n_d = (w_next == ST_RUN);
    w_cnt_clr       = sw_rst_req || (w_next != r_state);
    w_timeout       = !sw_rst_req && (r_state == ST_WAIT_LOCK) && !w_lk &&
                      (r_cnt == C_TIMEOUT_LAST);
    w_loss          = !sw_rst_req && (r_state == ST_RUN) && !w_lk;
  end

  // A loss on the same edge as a clear leaves the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_lost     <= 1'b0;
      r_relock_count  <= '0;
      r_timeout_count <= '0;
    end else begin
      if (w_loss)             r_lock_lost <= 1'b1;
      else if (clr_lock_lost) r_lock_lost <= 1'b0;
      if (w_loss)
        r_relock_count <= CNT_W'(sat_inc(32'(r_relock_count), C_SAT_MAX));
      if (w_timeout)
        r_timeout_count <= CNT_W'(sat_inc(32'(r_timeout_count), C_SAT_MAX));
    end
  end

  assign pll_rst       = r_pll_rst;
  assign sys_reset_n   = r_sys_reset_n;
  assign state_o       = r_state;
  assign lock_lost     = r_lock_lost;
  assign relock_count  = r_relock_count;
  assign timeout_count = r_timeout_count;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pll_reset_sequencer: directed plus random lock stimulus against a  |
// | timestamp-based reference model of the sequencer.                     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_pll_reset_sequencer;

  localparam int SYNC_STAGES    = 2;
  localparam int PLL_RST_CYCLES = 4;
  localparam int LOCK_TIMEOUT   = 20;
  localparam int STABLE_CYCLES  = 8;
  localparam int CNT_W          = 8;
  localparam int SAT            = 255;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             lock_in = 1'b0;
  logic             sw_in = 1'b0;
  logic             clr_in = 1'b0;
  logic             pll_rst;
  logic             sys_reset_n;
  logic [1:0]       state_o;
  logic             lock_lost;
  logic [CNT_W-1:0] relock_count;
  logic [CNT_W-1:0] timeout_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: state held as a name index plus the edge it was entered on.
  int m_n, m_enter, m_st, m_relock, m_tout;
  bit m_lost, m_pll, m_sys;
  bit lkq[$];

  pll_reset_sequencer #(
    .SYNC_STAGES   (SYNC_STAGES),
    .PLL_RST_CYCLES(PLL_RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pll_locked_async(lock_in),
    .sw_rst_req      (sw_in),
    .clr_lock_lost   (clr_in),
    .pll_rst         (pll_rst),
    .sys_reset_n     (sys_reset_n),
    .state_o         (state_o),
    .lock_lost       (lock_lost),
    .relock_count    (relock_count),
    .timeout_count   (timeout_count)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] dut_pack();
    return {11'd0, timeout_count, relock_count, lock_lost, sys_reset_n, pll_rst, state_o};
  endfunction

  function automatic logic [31:0] model_pack();
    return {11'd0, 8'(m_tout), 8'(m_relock), m_lost, m_sys, m_pll, 2'(m_st)};
  endfunction

  task automatic model_reset();
    lkq.delete();
    for (int i = 0; i < SYNC_STAGES; i++) lkq.push_back(1'b0);
    m_n = 0; m_enter = 0; m_st = 0;
    m_relock = 0; m_tout = 0; m_lost = 0; m_pll = 1; m_sys = 0;
  endtask

  task automatic model_edge();
    bit lk, ev_to, ev_loss;
    int dur, nxt;
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_n++;
    lk = lkq.pop_front();
    lkq.push_back(lock_in);
    dur = m_n - m_enter;  // edges spent in the current state including this one
    nxt = m_st; ev_to = 0; ev_loss = 0;
    if (sw_in) nxt = 0;
    else if (m_st == 0) begin
      if (dur == PLL_RST_CYCLES) nxt = 1;
    end else if (m_st == 1) begin
      if (lk) nxt = 2;
      else if (dur == LOCK_TIMEOUT) begin nxt = 0; ev_to = 1; end
    end else if (m_st == 2) begin
      if (!lk) nxt = 1;
      else if (dur == STABLE_CYCLES) nxt = 3;
    end else begin
      if (!lk) begin nxt = 0; ev_loss = 1; end
    end
    if (sw_in || nxt != m_st) m_enter = m_n;
    if (ev_loss) m_lost = 1;
    else if (clr_in) m_lost = 0;
    if (ev_loss && m_relock < SAT) m_relock++;
    if (ev_to && m_tout < SAT) m_tout++;
    m_st = nxt;
    m_pll = (nxt == 0);
    m_sys = (nxt == 3);
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("cycle_outputs", dut_pack(), model_pack());
  endtask

  task automatic wait_state(input logic [1:0] target, input int budget, input string tag);
    int k = 0;
    while (state_o !== target && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(state_o), 32'(target));
  endtask

  initial begin
    int k, r0, t0, hold;
    model_reset();
    step();
    step();
    reset_n = 1'b1;

    // Power-up: PLL reset pulse length
    k = 0;
    do begin step(); k++; end while (pll_rst && k < 50);
    check("t1_pll_rst_edges", 32'(k), 32'd4);
    check("t1_state_wait", {30'd0, state_o}, 32'd1);
    check("t1_sys_low", 32'(sys_reset_n), 32'd0);

    // Lock arrives two cycles into WAIT_LOCK
    step();
    step();
    lock_in = 1'b1;
    k = 0;
    do begin step(); k++; end while (!sys_reset_n && k < 100);
    check("t2_release_latency", 32'(k), 32'd11);
    check("t2_state_run", {30'd0, state_o}, 32'd3);

    // Loss of lock in RUN
    lock_in = 1'b0;
    k = 0;
    do begin step(); k++; end while (sys_reset_n && k < 50);
    check("t5_loss_latency", 32'(k), 32'd3);
    check("t5_lost_relock", {lock_lost, relock_count}, {1'b1, 8'd1});
    clr_in = 1'b1;
    step();
    clr_in = 1'b0;
    check("t5_lost_cleared", 32'(lock_lost), 32'd0);
    lock_in = 1'b1;
    wait_state(2'd3, 100, "t5_back_to_run");
    lock_in = 1'b0;
    clr_in = 1'b1;
    for (int i = 0; i < 3; i++) step();
    clr_in = 1'b0;
    check("t5_set_beats_clear", {lock_lost, relock_count}, {1'b1, 8'd2});

    // Lock glitch during STABILIZE
    sw_in = 1'b1;
    step();
    sw_in = 1'b0;
    wait_state(2'd1, 20, "t3_wait_lock");
    t0 = int'(timeout_count);
    lock_in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("t3_in_stabilize", {30'd0, state_o}, 32'd2);
    lock_in = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("t3_back_to_wait", {30'd0, state_o}, 32'd1);
    lock_in = 1'b1;
    k = 0;
    do begin step(); k++; end while (!sys_reset_n && k < 100);
    check("t3_release_latency", 32'(k), 32'd11);
    check("t3_no_timeout", 32'(timeout_count), 32'(t0));

    // Lock never arrives: timeout windows and saturation
    sw_in = 1'b1;
    lock_in = 1'b0;
    step();
    sw_in = 1'b0;
    wait_state(2'd1, 20, "t4_wait_lock");
    for (int i = 0; i < 3 * LOCK_TIMEOUT + 2 * PLL_RST_CYCLES; i++) step();
    check("t4_three_timeouts", 32'(timeout_count), 32'd3);
    for (int i = 0; i < 300 * (LOCK_TIMEOUT + PLL_RST_CYCLES); i++) step();
    check("t4_saturated", 32'(timeout_count), 32'd255);

    // Software restart from RUN, then asynchronous reset mid-STABILIZE
    lock_in = 1'b1;
    wait_state(2'd3, 100, "t6_run");
    r0 = int'(relock_count);
    t0 = int'(timeout_count);
    sw_in = 1'b1;
    step();
    sw_in = 1'b0;
    check("t6_sw_restart", {14'd0, timeout_count, relock_count, sys_reset_n, pll_rst},
          {14'd0, 8'(t0), 8'(r0), 1'b0, 1'b1});
    wait_state(2'd2, 20, "t6_stabilize");
    step();
    step();
    #2 reset_n = 1'b0;
    #1 check("t6_async_reset", dut_pack(), {11'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 2'd0});
    model_reset();
    step();
    step();
    reset_n = 1'b1;

    // Random lock behaviour with occasional restart and clear requests
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        lock_in = ($urandom_range(0, 99) < 70);
        hold = lock_in ? $urandom_range(1, 40) : $urandom_range(1, 30);
      end
      hold--;
      sw_in  = ($urandom_range(0, 255) == 0);
      clr_in = ($urandom_range(0, 15) == 0);
      step();
    end
    sw_in = 1'b0;
    clr_in = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
